logic_wb_buffer: RTL and testbench
==================================

# logic_wb_buffer

Result-side companion to `logic_unit`. It accepts each 32-bit logic result together with its destination-register tag and buffers it in a small in-order FIFO. It then drains the buffer to the register-file write port through a valid/ready handshake, attaching zero and negative flags to every entry. It also reports whether any tag is still pending, so that decode can detect read-after-write hazards on results not yet written back.

## Interface
- `DATA_W`, 32, result width
- `TAG_W`, 5, destination-register tag width
- `DEPTH`, 4, number of entries; must be a power of two, ≥2
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  result present on `in_data`/`in_tag`
- `in_ready`  out  1  buffer can accept this cycle
- `in_data`  in  DATA_W  result from logic unit
- `in_tag`  in  TAG_W  destination register
- `wb_valid`  out  1  head entry available
- `wb_ready`  in  1  register file accepts head entry
- `wb_data`  out  DATA_W  head result
- `wb_tag`  out  TAG_W  head destination
- `wb_zero`  out  1  head result == 0
- `wb_neg`  out  1  head result bit DATA_W-1
- `flush`  in  1  synchronous discard of all entries
- `chk_tag`  in  TAG_W  tag queried by decode
- `chk_hit`  out  1  some buffered entry has tag == `chk_tag`
- `count`  out  $clog2(DEPTH)+1  number of valid entries

## Operation
- Storage: DEPTH entries of {data, tag, zero, neg}, plus a per-entry valid bit. `wr_ptr` and `rd_ptr` are each $clog2(DEPTH) bits and wrap modulo DEPTH. `count` is a separate counter from 0 to DEPTH.
- Push: occurs when `in_valid & in_ready`. Write to `mem[wr_ptr]` and set its valid bit.
  - `zero = (in_data == 0)` and `neg = in_data[DATA_W-1]` are computed at push and stored.
  - `wr_ptr` increments.
- Pop: occurs when `wb_valid & wb_ready`. Clear the valid bit of `mem[rd_ptr]`; `rd_ptr` increments.
- `in_ready = (count != DEPTH)`. There is no pass-through when full: a push is refused on a full buffer even if a pop happens in the same cycle.
- `wb_valid = (count != 0)`. `wb_data`, `wb_tag`, `wb_zero` and `wb_neg` are a combinational read of `mem[rd_ptr]`.
  - When `wb_valid=0` these outputs are don't-care.
  - Once `wb_valid` is asserted, the head must hold stable until it is popped.
- Simultaneous push and pop (count between 1 and DEPTH-1): both take effect and `count` is unchanged.
- Push and pop at count 0: only the push can occur, since `wb_valid=0`.
- `chk_hit` is the OR over all entries of (valid bit & tag == `chk_tag`).
  - It is combinational from registered state only; it does not see an entry being pushed in the current cycle.
  - An entry being popped in the current cycle still reports a hit.
- Flush takes priority over push and pop.
  - At the next edge: count=0, pointers=0, all valid bits=0.
  - A same-cycle push is dropped; a same-cycle pop has no effect beyond the flush.
- The buffer emits results strictly in arrival order. Duplicate tags are allowed; `chk_hit` stays high until the last matching entry drains.

## Timing
- Reset (async assert, deasserted synchronously by the system): `count`=0, pointers=0, valid bits=0, `wb_valid`=0, `in_ready`=1, `chk_hit`=0. Data contents are don't-care.
- Reset asserted mid-operation: all entries are lost immediately, without waiting for a clock edge.
- Latency: a result pushed at edge N appears on `wb_*` with `wb_valid=1` after edge N, i.e. in the cycle following the push.
- Throughput: one push and one pop per cycle sustained when 0<count<DEPTH.
- `in_ready` depends only on state, so there is no combinational path `wb_ready`→`in_ready`.
- `chk_hit` rises in the cycle after a push edge and falls in the cycle after the pop edge of the last matching entry.
- Pointer wrap: after DEPTH pushes `wr_ptr` returns to 0. Data integrity must hold across any number of wraps.

## Test plan
- Reset, then push `in_data=32'hF0F0F0FF`, `tag=3` with `wb_ready=0` → next cycle `wb_valid=1`, `wb_data=F0F0F0FF`, `wb_tag=3`, `wb_neg=1`, `wb_zero=0`, `count=1`, `chk_hit=1` for `chk_tag=3` and 0 for `chk_tag=4`.
- Push 4 entries (data 0, 1, 2, 3; tags 1–4) with `wb_ready=0` → `count=4`, `in_ready=0`. A 5th push is refused. Drain → outputs appear in order 0, 1, 2, 3; the first entry has `wb_zero=1`.
- Continuous `in_valid=1` and `wb_ready=1` for 10 cycles with incrementing data → `count` stays at 1 after the first cycle and outputs are in order across pointer wrap.
- Full buffer, `in_valid=1` and `wb_ready=1` in the same cycle → the pop occurs, the push is refused, and `count` goes 4→3.
- `count=3` with `flush=1` and `in_valid=1` → next cycle `count=0`, `wb_valid=0`, `chk_hit=0`, and the pushed data is not present.
- Assert `rst_n=0` mid-cycle with `count=2` → `wb_valid`, `count` and `chk_hit` go to 0 immediately, without waiting for `clk`.

Source files
------------

// File: rtl/logic_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : logic_wb_buffer
// Brief    : In-order write-back buffer for logic-unit results. Stores
//            {data, tag, zero, neg} per entry, drains to the register file
//            over valid/ready, and reports pending-tag hits for hazard
//            detection in decode.
// Revision : 1.0 - initial release
// ============================================================================
module logic_wb_buffer #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    // Producer side (logic unit)
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [TAG_W-1:0]           in_tag,
    // Consumer side (register-file write port)
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [DATA_W-1:0]          wb_data,
    output logic [TAG_W-1:0]           wb_tag,
    output logic                       wb_zero,
    output logic                       wb_neg,
    // Control and status
    input  logic                       flush,
    input  logic [TAG_W-1:0]           chk_tag,
    output logic                       chk_hit,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    // Entry storage. Payload needs no reset: the valid bits and count
    // decide whether a location is meaningful.
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [TAG_W-1:0]  r_tag  [DEPTH];
    logic [DEPTH-1:0]  r_zero;
    logic [DEPTH-1:0]  r_neg;
    logic [DEPTH-1:0]  r_vld;

    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_in_zero;
    logic              w_in_neg;
    logic              w_hit;

    // Status derived purely from registered state, so in_ready has no
    // combinational dependence on wb_ready (no pass-through when full).
    always_comb begin
        w_full  = (r_count == c_FULL);
        w_empty = (r_count == '0);
    end

    // Handshake qualification; flush overrides both transfers.
    always_comb begin
        w_push = in_valid & ~w_full  & ~flush;
        w_pop  = wb_ready & ~w_empty & ~flush;
    end

    // Flags are computed once at push time and stored with the entry.
    always_comb begin
        w_in_zero = (in_data == '0);
        w_in_neg  = in_data[DATA_W-1];
    end

    // Payload write on push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wr_ptr] <= in_data;
            r_tag[r_wr_ptr]  <= in_tag;
            r_zero[r_wr_ptr] <= w_in_zero;
            r_neg[r_wr_ptr]  <= w_in_neg;
        end
    end

    // Per-entry valid bits: set on push, cleared on pop, all cleared on flush.
    // Push and pop never target the same slot in one cycle unless the buffer
    // is full, and a full buffer refuses the push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else if (flush) begin
            r_vld <= '0;
        end else begin
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
            end
            if (w_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
            end
        end
    end

    // Write pointer: wraps naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
        end
    end

    // Read pointer: advances on each accepted pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
        end
    end

    // Occupancy counter; simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Hazard check over registered entries only; an entry being pushed this
    // cycle is not visible yet, one being popped this cycle still hits.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_tag[i] == chk_tag)) begin
                w_hit = 1'b1;
            end
        end
    end

    // Output mapping: head entry is a combinational read at rd_ptr.
    always_comb begin
        in_ready = ~w_full;
        wb_valid = ~w_empty;
        wb_data  = r_data[r_rd_ptr];
        wb_tag   = r_tag[r_rd_ptr];
        wb_zero  = r_zero[r_rd_ptr];
        wb_neg   = r_neg[r_rd_ptr];
        chk_hit  = w_hit;
        count    = r_count;
    end

endmodule
`default_nettype wire

// File: tb/tb_logic_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_wb_buffer
// Brief    : Directed self-checking bench for logic_wb_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_wb_buffer;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [TAG_W-1:0]  in_tag;
    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [TAG_W-1:0]  wb_tag;
    logic              wb_zero;
    logic              wb_neg;
    logic              flush;
    logic [TAG_W-1:0]  chk_tag;
    logic              chk_hit;
    logic [2:0]        count;

    int checks = 0;
    int errors = 0;

    logic_wb_buffer #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_tag   (in_tag),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_data  (wb_data),
        .wb_tag   (wb_tag),
        .wb_zero  (wb_zero),
        .wb_neg   (wb_neg),
        .flush    (flush),
        .chk_tag  (chk_tag),
        .chk_hit  (chk_hit),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1ns before driving or sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t);
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0;
        wb_ready = 1'b0; flush = 1'b0; chk_tag = '0;
        #12;
        checks++;
        if (count !== 3'd0 || wb_valid !== 1'b0 || in_ready !== 1'b1 || chk_hit !== 1'b0) begin
            errors++;
            $display("FAIL reset: count=%0d wb_valid=%b in_ready=%b chk_hit=%b, want 0 0 1 0",
                     count, wb_valid, in_ready, chk_hit);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 32'hF0F0_F0FF; in_tag = 5'd3; wb_ready = 1'b0; chk_tag = 5'd3;
        #1;
        checks++;
        if (chk_hit !== 1'b0) begin
            errors++;
            $display("FAIL single_hit_before_edge: chk_hit=%b want 0", chk_hit);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'hF0F0_F0FF || wb_tag !== 5'd3 ||
            wb_neg !== 1'b1 || wb_zero !== 1'b0 || count !== 3'd1) begin
            errors++;
            $display("FAIL single_head: valid=%b data=%h tag=%0d neg=%b zero=%b count=%0d, want 1 f0f0f0ff 3 1 0 1",
                     wb_valid, wb_data, wb_tag, wb_neg, wb_zero, count);
        end
        checks++;
        if (chk_hit !== 1'b1) begin
            errors++;
            $display("FAIL single_hit_tag3: chk_hit=%b want 1", chk_hit);
        end
        chk_tag = 5'd4;
        #1;
        checks++;
        if (chk_hit !== 1'b0) begin
            errors++;
            $display("FAIL single_hit_tag4: chk_hit=%b want 0", chk_hit);
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: count=%0d wb_valid=%b want 0 0", count, wb_valid);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) push_one(DATA_W'(i), TAG_W'(i + 1));
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: count=%0d in_ready=%b want 4 0", count, in_ready);
        end
        push_one(32'd99, 5'd9);
        chk_tag = 5'd9;
        #1;
        checks++;
        if (count !== 3'd4 || chk_hit !== 1'b0) begin
            errors++;
            $display("FAIL fill_refused: count=%0d chk_hit=%b want 4 0", count, chk_hit);
        end
        chk_tag = 5'd4;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (wb_valid !== 1'b1 || wb_data !== DATA_W'(i) || wb_tag !== TAG_W'(i + 1) ||
                wb_zero !== (i == 0) || chk_hit !== 1'b1) begin
                errors++;
                $display("FAIL drain_order[%0d]: valid=%b data=%0d tag=%0d zero=%b hit=%b, want 1 %0d %0d %b 1",
                         i, wb_valid, wb_data, wb_tag, wb_zero, chk_hit, i, i + 1, (i == 0));
            end
            wb_ready = 1'b1;
            step();
            wb_ready = 1'b0;
        end
        checks++;
        if (wb_valid !== 1'b0 || count !== 3'd0 || chk_hit !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: valid=%b count=%0d hit=%b want 0 0 0", wb_valid, count, chk_hit);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; wb_ready = 1'b1; in_tag = 5'd12;
        for (int k = 0; k < 10; k++) begin
            in_data = DATA_W'(100 + k);
            #1;
            if (k > 0) begin
                checks++;
                if (count !== 3'd1 || wb_valid !== 1'b1 || wb_data !== DATA_W'(100 + k - 1)) begin
                    errors++;
                    $display("FAIL b2b[%0d]: count=%0d valid=%b data=%0d, want 1 1 %0d",
                             k, count, wb_valid, wb_data, 100 + k - 1);
                end
            end
            step();
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (wb_data !== 32'd109 || count !== 3'd1) begin
            errors++;
            $display("FAIL b2b_last: data=%0d count=%0d want 109 1", wb_data, count);
        end
        step();
        wb_ready = 1'b0;
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL b2b_empty: count=%0d want 0", count);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) push_one(DATA_W'(32'h10 + i), TAG_W'(20 + i));
        in_valid = 1'b1; in_data = 32'hAA; in_tag = 5'd30; wb_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd3 || wb_data !== 32'h11) begin
            errors++;
            $display("FAIL full_pushpop: count=%0d data=%h want 3 11", count, wb_data);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (wb_valid !== 1'b1 || wb_data !== DATA_W'(32'h10 + i)) begin
                errors++;
                $display("FAIL full_drain[%0d]: valid=%b data=%h want 1 %h", i, wb_valid, wb_data, 32'h10 + i);
            end
            step();
        end
        wb_ready = 1'b0;
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_refused_gone: wb_valid=%b data=%h want valid 0", wb_valid, wb_data);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) push_one(DATA_W'(32'h21 + i), TAG_W'(7 + i));
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL flush_pre: count=%0d want 3", count);
        end
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h55; in_tag = 5'd10; wb_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b0; chk_tag = 5'd10;
        #1;
        checks++;
        if (count !== 3'd0 || wb_valid !== 1'b0 || chk_hit !== 1'b0) begin
            errors++;
            $display("FAIL flush_post: count=%0d valid=%b hit=%b want 0 0 0", count, wb_valid, chk_hit);
        end
        chk_tag = 5'd7;
        #1;
        checks++;
        if (chk_hit !== 1'b0) begin
            errors++;
            $display("FAIL flush_old_tag: chk_hit=%b want 0", chk_hit);
        end
        push_one(32'h66, 5'd11);
        checks++;
        if (count !== 3'd1 || wb_data !== 32'h66 || wb_tag !== 5'd11) begin
            errors++;
            $display("FAIL flush_repush: count=%0d data=%h tag=%0d want 1 66 11", count, wb_data, wb_tag);
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        push_one(32'h77, 5'd15);
        push_one(32'h78, 5'd16);
        chk_tag = 5'd15;
        #1;
        checks++;
        if (count !== 3'd2 || chk_hit !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: count=%0d hit=%b want 2 1", count, chk_hit);
        end
        // Land reset between edges: 1ns+1ns past posedge, before negedge.
        rst_n = 1'b0;
        #1;
        checks++;
        if (wb_valid !== 1'b0 || count !== 3'd0 || chk_hit !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL areset_immediate: valid=%b count=%0d hit=%b in_ready=%b want 0 0 0 1",
                     wb_valid, count, chk_hit, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (count !== 3'd0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_after: count=%0d valid=%b want 0 0", count, wb_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_back_to_back();
        test_full_push_pop();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so a stuck run still reports.
    initial begin
        #20000;
        $display("FAIL watchdog: sim time exceeded, want completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
